// File: rtl/act_pipe_pkg.sv
// ============================================================================
// act_pipe_pkg : shared types for the activation pipeline
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package act_pipe_pkg;

    typedef enum logic {FXP = 1'b0, FLP = 1'b1} dtype_t;
    typedef enum logic {Disable = 1'b0, Enable = 1'b1} sign_t;

    typedef struct packed {
        dtype_t     dtype;
        sign_t      sign;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;

    typedef enum logic [1:0] {
        ReLU  = 2'd0,
        STEP  = 2'd1,
        LReLU = 2'd2,
        CLIP  = 2'd3
    } actf_t;

    localparam dconf_t c_DEF_CONF = '{dtype: FXP, sign: Enable, prec: 8'd8, frac: 8'd3};

endpackage

`default_nettype wire

// File: rtl/act_lane.sv
// ============================================================================
// act_lane : combinational single-lane activation (ReLU/STEP/LReLU/CLIP)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module act_lane
    import act_pipe_pkg::*;
#(
    parameter dconf_t CONF     = c_DEF_CONF,
    parameter int     LSHIFT   = 2,
    parameter int     CLIP_INT = 6,
    localparam int    P        = int'(CONF.prec)
) (
    input  logic [P-1:0] x,
    input  actf_t        mode,
    output logic [P-1:0] y,
    output logic         clip
);

    localparam bit     c_SGN   = (CONF.sign == Enable);
    localparam longint c_MAXV  = c_SGN ? ((longint'(1) <<< (P-1)) - 1) : ((longint'(1) <<< P) - 1);
    localparam longint c_ONE   = longint'(1) <<< CONF.frac;
    localparam longint c_CLIPV = longint'(CLIP_INT) <<< CONF.frac;
    localparam logic [P-1:0] c_STEP = P'((c_ONE < c_MAXV) ? c_ONE : c_MAXV);
    localparam logic [P-1:0] c_CMAX = P'((c_CLIPV < c_MAXV) ? c_CLIPV : c_MAXV);

    logic                w_neg;
    logic signed [P-1:0] w_xs;
    logic signed [P-1:0] w_shr;
    logic                w_over;

    // Unsigned formats never see a negative value, so every neg path is dead.
    assign w_neg  = c_SGN && x[P-1];
    assign w_xs   = x;
    assign w_shr  = w_xs >>> LSHIFT;
    assign w_over = !w_neg && (x > c_CMAX);

    always_comb begin
        y    = x;
        clip = 1'b0;
        case (mode)
            ReLU:  y = w_neg ? '0 : x;
            STEP:  y = w_neg ? '0 : c_STEP;
            LReLU: y = w_neg ? w_shr : x;
            CLIP: begin
                y    = w_neg ? '0 : (w_over ? c_CMAX : x);
                clip = w_over;
            end
            default: y = x;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/act_pipe.sv
// ============================================================================
// act_pipe : two-stage multi-lane activation pipeline with valid/ready
//            handshakes and a saturating clip-event counter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module act_pipe
    import act_pipe_pkg::*;
#(
    parameter dconf_t CONF     = c_DEF_CONF,
    parameter int     LANES    = 4,
    parameter int     LSHIFT   = 2,
    parameter int     CLIP_INT = 6,
    parameter int     CNT_W    = 16,
    localparam int    P        = int'(CONF.prec)
) (
    input  logic               clk,
    input  logic               reset_,
    input  actf_t              mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*P-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*P-1:0] out_data,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   clip_cnt
);

    localparam int c_SUM_W = $clog2(LANES + 1);

    logic               s1_valid_q, s1_valid_d;
    logic [LANES*P-1:0] s1_data_q,  s1_data_d;
    actf_t              s1_mode_q,  s1_mode_d;
    logic               out_valid_q, out_valid_d;
    logic [LANES*P-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0]   clip_cnt_q,  clip_cnt_d;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic [LANES*P-1:0] w_lane_y;
    logic [LANES-1:0]   w_clip;
    logic [c_SUM_W-1:0] w_nclip;
    logic [CNT_W:0]     w_cnt_sum;

    assign w_s2_adv = !out_valid_q || out_ready;
    assign w_s1_adv = s1_valid_q && w_s2_adv;
    assign in_ready = !s1_valid_q || w_s2_adv;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            act_lane #(
                .CONF     (CONF),
                .LSHIFT   (LSHIFT),
                .CLIP_INT (CLIP_INT)
            ) u_lane (
                .x    (s1_data_q[i*P +: P]),
                .mode (s1_mode_q),
                .y    (w_lane_y[i*P +: P]),
                .clip (w_clip[i])
            );
        end
    endgenerate

    always_comb begin
        w_nclip = '0;
        for (int i = 0; i < LANES; i++) begin
            w_nclip = w_nclip + c_SUM_W'(w_clip[i]);
        end
    end

    // One spare MSB catches the carry so the counter can saturate instead of wrap.
    assign w_cnt_sum = {1'b0, clip_cnt_q} + {{(CNT_W + 1 - c_SUM_W){1'b0}}, w_nclip};

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        clip_cnt_d  = clip_cnt_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = mode;
            end
        end

        if (w_s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = w_lane_y;
            end
        end

        if (clr_cnt) begin
            clip_cnt_d = '0;
        end else if (w_s1_adv) begin
            clip_cnt_d = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= ReLU;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            clip_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            clip_cnt_q  <= clip_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign clip_cnt  = clip_cnt_q;

endmodule

`default_nettype wire
